// File: rtl/uart_rx_frame.sv
// UART receive deserializer: synchronizes the RX line, samples each bit at its
// centre and commits {stop, parity, data[7:0]} with parity/framing error flags.
module uart_rx_frame #(
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RX,
  output logic [9:0] RX_DATA_T,
  output logic       DATA_VALID,
  output logic       PAR_ERR,
  output logic       FRT_ERR,
  output logic       BUSY
);

  localparam int unsigned    CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      data_q, data_d;
  logic            parity_q, parity_d;

  logic            rx_meta_q, rx_s_q, rx_prev_q;
  logic            start_edge;
  logic            tick;
  logic            commit;

  logic [9:0]      rx_data_q;
  logic            valid_q, par_err_q, frt_err_q;

  // NOTE: the synchronizer and previous-sample flops reset to the idle level
  // (1) so that leaving reset can never look like a start edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // A held-low line (break, or after a framing error) gives no edge, so IDLE
  // cannot retrigger until the line has been seen high again.
  assign start_edge = rx_prev_q & ~rx_s_q;

  // START samples at half a bit; every later bit one full bit after that,
  // which lands each sample at the bit centre.
  assign tick = (state_q == S_START) ? (baud_cnt_q == HALF_LAST)
                                     : (baud_cnt_q == FULL_LAST);

  // NOTE: every variable written here gets a default first so no latch can be
  // inferred on paths where a state leaves it untouched.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    parity_d  = parity_q;
    commit    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_edge) state_d = S_START;
      end
      S_START: begin
        if (tick) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          data_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) state_d = S_PARITY;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (tick) begin
          parity_d = rx_s_q;
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Each tick ends a state (or a DATA bit), so clearing on tick is the
    // same as clearing on every state entry.
    if (state_q == S_IDLE || tick) baud_cnt_d = '0;
    else                           baud_cnt_d = baud_cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // update together from pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      data_q     <= 8'h00;
      parity_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
    end
  end

  // Commit registers: hold the last frame and its flags until the next commit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_data_q <= 10'h000;
      par_err_q <= 1'b0;
      frt_err_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= commit;
      if (commit) begin
        rx_data_q <= {rx_s_q, parity_q, data_q};
        par_err_q <= ((^data_q) ^ parity_q) != ODD;
        frt_err_q <= ~rx_s_q;
      end
    end
  end

  assign RX_DATA_T  = rx_data_q;
  assign DATA_VALID = valid_q;
  assign PAR_ERR    = par_err_q;
  assign FRT_ERR    = frt_err_q;
  assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed cases plus randomized frames
// scored against a bit-level frame model; even- and odd-parity instances share RX.
module tb_uart_rx_frame;

  localparam int BAUD      = 16;
  localparam int FRAME_LEN = 11 * BAUD;
  localparam int LAT_NOM   = BAUD / 2 + 10 * BAUD + 3;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [9:0] e_data, o_data;
  logic       e_valid, o_valid, e_par, o_par, e_frt, o_frt, e_busy, o_busy;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int e_pulses = 0, e_hi = 0, o_pulses = 0;
  int last_pulse_cyc = 0, prev_pulse_cyc = 0;
  int busy_hi = 0;
  logic e_valid_d = 1'b0;

  uart_rx_frame #(.BAUD_DIV(BAUD), .PARITY_ODD(0)) u_even (
    .CLK(clk), .RST_N(rst_n), .RX(rx),
    .RX_DATA_T(e_data), .DATA_VALID(e_valid),
    .PAR_ERR(e_par), .FRT_ERR(e_frt), .BUSY(e_busy)
  );

  uart_rx_frame #(.BAUD_DIV(BAUD), .PARITY_ODD(1)) u_odd (
    .CLK(clk), .RST_N(rst_n), .RX(rx),
    .RX_DATA_T(o_data), .DATA_VALID(o_valid),
    .PAR_ERR(o_par), .FRT_ERR(o_frt), .BUSY(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    e_valid_d <= e_valid;
    if (e_valid) e_hi <= e_hi + 1;
    if (e_valid && !e_valid_d) begin
      e_pulses       <= e_pulses + 1;
      prev_pulse_cyc <= last_pulse_cyc;
      last_pulse_cyc <= cyc;
    end
    if (o_valid) o_pulses <= o_pulses + 1;
    if (e_busy)  busy_hi  <= busy_hi + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BAUD) @(negedge clk);
  endtask

  int exp_pulses = 0;
  int fall_cyc   = 0;

  // Serial line model: start, 8 data bits LSB first, parity, stop.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
    exp_pulses++;
  endtask

  // Expected outcome from frame contents alone.
  task automatic check_frame(input string tag, input logic [7:0] d, input logic p, input logic s);
    logic ones_odd;
    int   lat;
    ones_odd = 1'b0;
    for (int i = 0; i < 8; i++) ones_odd = ones_odd ^ d[i];
    check({tag, ".pulses"}, e_pulses, exp_pulses);
    check({tag, ".opulses"}, o_pulses, exp_pulses);
    check({tag, ".onecycle"}, e_hi, exp_pulses);
    check({tag, ".data"}, e_data, {s, p, d});
    check({tag, ".odata"}, o_data, {s, p, d});
    check({tag, ".par_even"}, e_par, (ones_odd != p));
    check({tag, ".par_odd"}, o_par, (ones_odd == p));
    check({tag, ".frt"}, e_frt, !s);
    check({tag, ".busy"}, e_busy, 1'b0);
    lat = last_pulse_cyc - fall_cyc;
    check({tag, ".latency"}, (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1), 1'b1);
  endtask

  task automatic framing_hold();
    rx = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (e_busy) busy_hi = busy_hi;
    end
  endtask

  logic [7:0] rd;
  logic       rp, rs, par_ok;
  int         busy_before;
  logic [9:0] held;

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.outs", {e_busy, e_frt, e_par, e_valid, e_data}, 14'h0);
    rst_n = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
    check("idle.outs", {e_busy, e_frt, e_par, e_valid, e_data}, 14'h0);

    // Good frame, even parity
    send_frame(8'hA5, 1'b0, 1'b1);
    check_frame("a5_ok", 8'hA5, 1'b0, 1'b1);
    drive_bit(1'b1);

    // Wrong even parity (correct odd parity)
    send_frame(8'hA5, 1'b1, 1'b1);
    check_frame("a5_par", 8'hA5, 1'b1, 1'b1);
    drive_bit(1'b1);

    // Framing error, line held low afterwards: no retrigger
    send_frame(8'hA5, 1'b0, 1'b0);
    check_frame("a5_frt", 8'hA5, 1'b0, 1'b0);
    busy_before = busy_hi;
    framing_hold();
    check("frt.no_retrig_busy", busy_hi, busy_before);
    check("frt.no_retrig_pulse", e_pulses, exp_pulses);
    rx = 1'b1;
    repeat (2 * BAUD) @(negedge clk);

    // Short low glitch on idle line
    busy_before = busy_hi;
    held = e_data;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
    check("glitch.busy_seen", (busy_hi > busy_before), 1'b1);
    check("glitch.busy_end", e_busy, 1'b0);
    check("glitch.pulses", e_pulses, exp_pulses);
    check("glitch.data", e_data, held);

    // Back-to-back 0x00 then 0xFF with no idle gap
    send_frame(8'h00, 1'b0, 1'b1);
    check_frame("b2b_00", 8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    check_frame("b2b_ff", 8'hFF, 1'b0, 1'b1);
    check("b2b.spacing", last_pulse_cyc - prev_pulse_cyc, FRAME_LEN);
    drive_bit(1'b1);

    // Reset during data bit 4 abandons the frame
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    rx = 1'b1;
    repeat (BAUD / 2) @(negedge clk);
    check("rst.busy_before", e_busy, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.outs", {e_busy, e_frt, e_par, e_valid, e_data}, 14'h0);
    rst_n = 1'b1;
    repeat (12 * BAUD) @(negedge clk);
    check("rst.no_pulse", e_pulses, exp_pulses);
    send_frame(8'h3C, 1'b0, 1'b1);
    check_frame("after_rst", 8'h3C, 1'b0, 1'b1);

    // Randomized frames, random gaps (0 gives back-to-back)
    for (int n = 0; n < 10; n++) begin
      rd = 8'($urandom_range(0, 255));
      par_ok = ($urandom_range(0, 2) != 0);
      rp = (^rd) ^ !par_ok;
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rd, rp, rs);
      check_frame($sformatf("rnd%0d", n), rd, rp, rs);
      if (!rs) begin
        framing_hold();
        rx = 1'b1;
        repeat (BAUD) @(negedge clk);
      end
      repeat ($urandom_range(0, 2) * BAUD) @(negedge clk);
    end

    repeat (2 * BAUD) @(negedge clk);
    check("final.pulses", e_pulses, exp_pulses);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
